lcd_nibble_writer: RTL

- Hardware responder for the LCD write-request handshake. It replaces the software bit-banging of the character LCD's enable/rs/rw/data pins.
- Accepts one byte plus a register-select bit from a requester (the LCD menu state machine). Drives the HD44780-style 4-bit bus as two timed nibble strobes, waits the controller execution time, then acknowledges.
- Runs the 4-bit power-on init sequence after reset. Sits between lcd_fsm and the board LCD pins on the ram_clkout domain.

---
 rtl/lcd_nibble_writer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_writer.sv
// Drives an HD44780-style character LCD over its 4-bit bus: power-on init sequence,
// then one byte per req/req_ack handshake as two timed enable strobes plus a settle wait.
module lcd_nibble_writer #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 24,
  parameter int NIBBLE_GAP_CYC = 100,
  parameter int CMD_WAIT_CYC   = 4000,
  parameter int CLEAR_WAIT_CYC = 164000,
  parameter int POWERUP_CYC    = 1500000,
  parameter int INIT1_WAIT_CYC = 410000,
  parameter int INIT2_WAIT_CYC = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ack,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_enb,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_data
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(NIBBLE_GAP_CYC, CMD_WAIT_CYC)),
                                max2(max2(CLEAR_WAIT_CYC, POWERUP_CYC), max2(INIT1_WAIT_CYC, INIT2_WAIT_CYC)));
  localparam int TW = $clog2(MAX_CYC + 1);

  typedef logic [TW-1:0] timer_t;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT_SETUP,
    S_INIT_EN,
    S_INIT_GAP,
    S_INIT_WAIT,
    S_IDLE,
    S_SETUP_HI,
    S_EN_HI,
    S_GAP_HI,
    S_SETUP_LO,
    S_EN_LO,
    S_GAP_LO,
    S_SETTLE,
    S_ACK_WAIT
  } state_t;

  // A phase of N cycles loads N-1 and ends on the cycle the timer reads zero.
  function automatic timer_t phase_len(int n);
    return timer_t'(n - 1);
  endfunction

  function automatic timer_t init_wait(logic [1:0] step);
    case (step)
      2'd0:    return phase_len(INIT1_WAIT_CYC);
      2'd1:    return phase_len(INIT2_WAIT_CYC);
      default: return phase_len(CMD_WAIT_CYC);
    endcase
  endfunction

  state_t     state, state_nxt;
  timer_t     timer, timer_nxt;
  logic [1:0] init_step, init_step_nxt;
  logic       lat_rs;
  logic [7:0] lat_data;
  logic       load_req;
  logic       rs_nxt;
  logic [3:0] data_nxt;
  logic       done_nxt;
  logic       phase_end;
  logic       is_clear;

  assign phase_end = (timer == '0);
  // Clear display and return home need the long execution time.
  assign is_clear  = !lat_rs && (lat_data inside {8'h01, 8'h02, 8'h03});
  assign lcd_rw    = 1'b0;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = phase_end ? timer : timer - timer_t'(1);
    init_step_nxt = init_step;
    load_req      = 1'b0;
    rs_nxt        = lcd_rs;
    data_nxt      = lcd_data;
    done_nxt      = init_done;
    unique case (state)
      S_PWR_WAIT: if (phase_end) begin
        state_nxt = S_INIT_SETUP;
        timer_nxt = phase_len(SETUP_CYC);
        rs_nxt    = 1'b0;
        data_nxt  = 4'h3;
      end
      S_INIT_SETUP: if (phase_end) begin
        state_nxt = S_INIT_EN;
        timer_nxt = phase_len(EN_HIGH_CYC);
      end
      S_INIT_EN: if (phase_end) begin
        state_nxt = S_INIT_GAP;
        timer_nxt = phase_len(NIBBLE_GAP_CYC);
      end
      S_INIT_GAP: if (phase_end) begin
        state_nxt = S_INIT_WAIT;
        timer_nxt = init_wait(init_step);
      end
      S_INIT_WAIT: if (phase_end) begin
        if (init_step == 2'd3) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          // Init nibbles are 3, 3, 3 and finally 2 to switch into 4-bit mode.
          init_step_nxt = init_step + 2'd1;
          state_nxt     = S_INIT_SETUP;
          timer_nxt     = phase_len(SETUP_CYC);
          rs_nxt        = 1'b0;
          data_nxt      = (init_step == 2'd2) ? 4'h2 : 4'h3;
        end
      end
      S_IDLE: if (req && !req_ack) begin
        load_req  = 1'b1;
        state_nxt = S_SETUP_HI;
        timer_nxt = phase_len(SETUP_CYC);
        rs_nxt    = req_rs;
        data_nxt  = req_data[7:4];
      end
      S_SETUP_HI: if (phase_end) begin
        state_nxt = S_EN_HI;
        timer_nxt = phase_len(EN_HIGH_CYC);
      end
      S_EN_HI: if (phase_end) begin
        state_nxt = S_GAP_HI;
        timer_nxt = phase_len(NIBBLE_GAP_CYC);
      end
      S_GAP_HI: if (phase_end) begin
        state_nxt = S_SETUP_LO;
        timer_nxt = phase_len(SETUP_CYC);
        rs_nxt    = lat_rs;
        data_nxt  = lat_data[3:0];
      end
      S_SETUP_LO: if (phase_end) begin
        state_nxt = S_EN_LO;
        timer_nxt = phase_len(EN_HIGH_CYC);
      end
      S_EN_LO: if (phase_end) begin
        state_nxt = S_GAP_LO;
        timer_nxt = phase_len(NIBBLE_GAP_CYC);
      end
      S_GAP_LO: if (phase_end) begin
        state_nxt = S_SETTLE;
        timer_nxt = is_clear ? phase_len(CLEAR_WAIT_CYC) : phase_len(CMD_WAIT_CYC);
      end
      // A requester that dropped req before the settle ended gets no acknowledge.
      S_SETTLE: if (phase_end) begin
        state_nxt = req ? S_ACK_WAIT : S_IDLE;
      end
      S_ACK_WAIT: if (!req) begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_PWR_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_PWR_WAIT;
      timer     <= phase_len(POWERUP_CYC);
      init_step <= 2'd0;
      lat_rs    <= 1'b0;
      lat_data  <= 8'h00;
      lcd_enb   <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 4'h0;
      req_ack   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      init_step <= init_step_nxt;
      if (load_req) begin
        lat_rs   <= req_rs;
        lat_data <= req_data;
      end
      // Outputs are registered from the next state so they line up with the state register.
      lcd_enb   <= state_nxt inside {S_INIT_EN, S_EN_HI, S_EN_LO};
      lcd_rs    <= rs_nxt;
      lcd_data  <= data_nxt;
      req_ack   <= (state_nxt == S_ACK_WAIT);
      init_done <= done_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule
